// File: rtl/mnist_inference_sched.sv
// Frame sequencer for the two-layer MNIST datapath: start L1, start L2, capture class, report.
// Optional performance counters are built when SCHED_PERF_CNT_EN is defined.
module mnist_inference_sched #(
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TO_WIDTH       = 13
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ID_WIDTH-1:0] req_id_i,
    output logic                l1_start_o,
    input  logic                l1_done_i,
    output logic                l2_start_o,
    input  logic                l2_done_i,
    input  logic [3:0]          l2_class_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [ID_WIDTH-1:0] res_id_o,
    output logic [3:0]          res_class_o,
    output logic                res_error_o,
    output logic                err_layer_o,
`ifdef SCHED_PERF_CNT_EN
    output logic [31:0]         frame_cycles_o,
    output logic [15:0]         frames_ok_o,
    output logic [15:0]         frames_err_o,
`endif
    output logic                busy_o
);

    typedef enum logic [2:0] {
        StIdle, StL1Go, StL1Wait, StL2Go, StL2Wait, StL2Cap, StAbort, StResult
    } state_e;

    localparam logic [TO_WIDTH-1:0] WdLast = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_WIDTH-1:0] WdMax  = '1;

    state_e              state_q;
    logic [TO_WIDTH-1:0] wd_q;
    logic [TO_WIDTH-1:0] wd_inc;
    logic [ID_WIDTH-1:0] tag_q;
    logic                wd_expired;

    assign req_ready_o = (state_q == StIdle);
    assign res_id_o    = tag_q;
    assign wd_expired  = (wd_q == WdLast);
    // Saturating increment so the watchdog can never wrap back to a live count.
    assign wd_inc      = (wd_q == WdMax) ? wd_q : wd_q + TO_WIDTH'(1);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            wd_q        <= '0;
            tag_q       <= '0;
            l1_start_o  <= 1'b0;
            l2_start_o  <= 1'b0;
            res_valid_o <= 1'b0;
            res_class_o <= 4'h0;
            res_error_o <= 1'b0;
            err_layer_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            l1_start_o <= 1'b0;
            l2_start_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        tag_q      <= req_id_i;
                        l1_start_o <= 1'b1;
                        busy_o     <= 1'b1;
                        state_q    <= StL1Go;
                    end
                end
                StL1Go: begin
                    wd_q    <= '0;
                    state_q <= StL1Wait;
                end
                StL1Wait: begin
                    wd_q <= wd_inc;
                    // A done on the expiry cycle takes priority over the abort.
                    if (l1_done_i) begin
                        l2_start_o <= 1'b1;
                        state_q    <= StL2Go;
                    end else if (wd_expired) begin
                        err_layer_o <= 1'b0;
                        state_q     <= StAbort;
                    end
                end
                StL2Go: begin
                    wd_q    <= '0;
                    state_q <= StL2Wait;
                end
                StL2Wait: begin
                    wd_q <= wd_inc;
                    if (l2_done_i) begin
                        state_q <= StL2Cap;
                    end else if (wd_expired) begin
                        err_layer_o <= 1'b1;
                        state_q     <= StAbort;
                    end
                end
                StL2Cap: begin
                    res_class_o <= l2_class_i;
                    res_error_o <= 1'b0;
                    err_layer_o <= 1'b0;
                    res_valid_o <= 1'b1;
                    state_q     <= StResult;
                end
                StAbort: begin
                    res_class_o <= 4'hF;
                    res_error_o <= 1'b1;
                    res_valid_o <= 1'b1;
                    state_q     <= StResult;
                end
                StResult: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] cyc_q;
    logic [31:0] frame_cycles_q;
    logic [15:0] frames_ok_q;
    logic [15:0] frames_err_q;

    assign frame_cycles_o = frame_cycles_q;
    assign frames_ok_o    = frames_ok_q;
    assign frames_err_o   = frames_err_q;

    // cyc_q counts cycles since accept; the +2 folds in the accept and RESULT-entry cycles.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cyc_q          <= '0;
            frame_cycles_q <= '0;
            frames_ok_q    <= '0;
            frames_err_q   <= '0;
        end else begin
            if (state_q == StIdle && req_valid_i) begin
                cyc_q <= 32'd1;
            end else if (state_q != StIdle && state_q != StResult) begin
                cyc_q <= cyc_q + 32'd1;
            end
            if (state_q == StL2Cap || state_q == StAbort) begin
                frame_cycles_q <= cyc_q + 32'd2;
            end
            if (state_q == StResult && res_ready_i) begin
                if (res_error_o) begin
                    frames_err_q <= frames_err_q + 16'd1;
                end else begin
                    frames_ok_q <= frames_ok_q + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_mnist_inference_sched.sv
// Randomized bench for mnist_inference_sched: behavioural layer models plus a timing/result model.
module tb_mnist_inference_sched;

    localparam int T = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid, req_ready, l1_start, l1_done, l2_start, l2_done;
    logic [7:0] req_id, res_id;
    logic [3:0] l2_class, res_class;
    logic       res_valid, res_ready, res_error, err_layer, busy;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] frame_cycles;
    logic [15:0] frames_ok, frames_err;
`endif

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int last_hs = -1;
    int ok_cnt = 0;
    int err_cnt = 0;

    mnist_inference_sched #(
        .ID_WIDTH      (8),
        .TIMEOUT_CYCLES(T),
        .TO_WIDTH      (7)
    ) u_dut (
        .clk_i        (clk),
        .reset_ni     (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_id_i     (req_id),
        .l1_start_o   (l1_start),
        .l1_done_i    (l1_done),
        .l2_start_o   (l2_start),
        .l2_done_i    (l2_done),
        .l2_class_i   (l2_class),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_id_o     (res_id),
        .res_class_o  (res_class),
        .res_error_o  (res_error),
        .err_layer_o  (err_layer),
`ifdef SCHED_PERF_CNT_EN
        .frame_cycles_o(frame_cycles),
        .frames_ok_o   (frames_ok),
        .frames_err_o  (frames_err),
`endif
        .busy_o       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_counters();
`ifdef SCHED_PERF_CNT_EN
        check_eq("frames_ok", 32'(frames_ok), ok_cnt);
        check_eq("frames_err", 32'(frames_err), err_cnt);
`endif
    endtask

    // One frame: layer models reply d1/d2 cycles after their start pulse (never if beyond budget).
    task automatic run_frame(input logic [7:0] id, input int d1, input int d2,
                             input logic [3:0] cls, input int bp, input bit hold, input bit stray);
        int  acc, l1s, l2s, l2d, rv, l1n, l2n, c, exp_l2s, exp_rv;
        bit  e1, e2, err;
        acc = -1; l1s = -1; l2s = -1; l2d = -1; rv = -1; l1n = 0; l2n = 0;
        req_id = id;
        if (last_hs >= 0) req_valid = 1'b1;
        for (int k = 0; k < 600 && rv < 0; k++) begin
            @(negedge clk);
            c = cyc;
            res_ready = 1'b0;
            if (l1_start) begin l1n++; if (l1s < 0) l1s = c; end
            if (l2_start) begin l2n++; if (l2s < 0) l2s = c; end
            if (res_valid && acc >= 0) rv = c;
            if (acc < 0) req_valid = 1'b1;
            else if (!hold) req_valid = 1'b0;
            l1_done = (l1s >= 0 && c == l1s + d1);
            l2_done = (l2s >= 0 && c == l2s + d2) || (stray && l1s >= 0 && l2s < 0 && c == l1s + 2);
            l2_class = (l2d >= 0 && c == l2d + 1) ? cls : 4'($urandom);
            if (l2s >= 0 && c == l2s + d2) l2d = c;
            if (acc < 0 && req_ready) begin
                acc = c;
                if (last_hs >= 0) check_eq("accept_next_cycle", acc, last_hs + 1);
            end
        end
        l1_done = 1'b0;
        l2_done = 1'b0;
        if (rv < 0) begin
            check_eq("result_seen", 0, 1);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            req_valid = 1'b0;
            ok_cnt = 0; err_cnt = 0; last_hs = -1;
            return;
        end
        e1 = d1 > T;
        e2 = !e1 && d2 > T;
        err = e1 || e2;
        exp_l2s = acc + 1 + d1 + 1;
        exp_rv = e1 ? acc + 1 + T + 2 : (e2 ? exp_l2s + T + 2 : exp_l2s + d2 + 2);
        check_eq("l1_start_time", l1s, acc + 1);
        check_eq("l1_start_pulses", l1n, 1);
        check_eq("l2_start_pulses", l2n, e1 ? 0 : 1);
        if (!e1) check_eq("l2_start_time", l2s, exp_l2s);
        check_eq("res_valid_time", rv, exp_rv);
        check_eq("res_id", 32'(res_id), 32'(id));
        check_eq("res_class", 32'(res_class), err ? 32'hF : 32'(cls));
        check_eq("res_error", 32'(res_error), 32'(err));
        if (err) check_eq("err_layer", 32'(err_layer), 32'(e2));
        check_eq("busy_result", 32'(busy), 1);
        check_eq("req_ready_result", 32'(req_ready), 0);
`ifdef SCHED_PERF_CNT_EN
        check_eq("frame_cycles", frame_cycles, exp_rv - acc + 1);
`endif
        check_counters();
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            res_ready = 1'b0;
            check_eq("bp_res_valid", 32'(res_valid), 1);
            check_eq("bp_res_id", 32'(res_id), 32'(id));
            check_eq("bp_res_class", 32'(res_class), err ? 32'hF : 32'(cls));
            check_eq("bp_res_error", 32'(res_error), 32'(err));
            check_eq("bp_req_ready", 32'(req_ready), 0);
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        check_eq("hs_req_ready", 32'(req_ready), 0);
        check_eq("hs_res_valid", 32'(res_valid), 1);
        last_hs = cyc;
        if (err) err_cnt++; else ok_cnt++;
    endtask

    task automatic reset_mid_frame();
        int acc, l1s, l2s, c, hits;
        bit reached;
        acc = -1; l1s = -1; l2s = -1; reached = 0; hits = 0;
        req_id = 8'h77;
        for (int k = 0; k < 300 && !reached; k++) begin
            @(negedge clk);
            c = cyc;
            res_ready = 1'b0;
            if (l1_start && l1s < 0) l1s = c;
            if (l2_start && l2s < 0) l2s = c;
            if (acc < 0) req_valid = 1'b1; else req_valid = 1'b0;
            l1_done = (l1s >= 0 && c == l1s + 4);
            l2_done = 1'b0;
            if (acc < 0 && req_ready) acc = c;
            if (l2s >= 0 && c == l2s + 3) reached = 1;
        end
        check_eq("rst_reached_l2_wait", 32'(reached), 1);
        l1_done = 1'b0;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_req_ready", 32'(req_ready), 1);
        check_eq("rst_res_valid", 32'(res_valid), 0);
        ok_cnt = 0; err_cnt = 0; last_hs = -1;
        check_counters();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            l2_done = (i == 2);
            if (res_valid || l1_start || l2_start || busy) hits++;
        end
        l2_done = 1'b0;
        check_eq("rst_no_activity", hits, 0);
    endtask

    initial begin
        int d1, d2;
        req_valid = 1'b0; req_id = '0; l1_done = 1'b0; l2_done = 1'b0;
        l2_class = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", 32'(busy), 0);
        check_eq("reset_req_ready", 32'(req_ready), 1);
        check_eq("reset_res_valid", 32'(res_valid), 0);
        check_eq("reset_starts", {30'd0, l1_start, l2_start}, 0);
        check_eq("reset_res_class", 32'(res_class), 0);
        check_eq("reset_res_id", 32'(res_id), 0);
        check_eq("reset_res_error", {30'd0, res_error, err_layer}, 0);
        check_counters();
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(8'h2A, 40, 18, 4'd7, 0, 1'b0, 1'b0);
        run_frame(8'h55, 5, 6, 4'd3, 10, 1'b1, 1'b0);
        run_frame(8'h56, 7, 9, 4'd9, 0, 1'b0, 1'b0);
        run_frame(8'h10, 100000, 5, 4'd1, 2, 1'b0, 1'b0);
        run_frame(8'h11, T, 4, 4'd2, 0, 1'b0, 1'b0);
        run_frame(8'h12, T + 1, 4, 4'd2, 0, 1'b0, 1'b0);
        run_frame(8'h13, 3, T, 4'd5, 1, 1'b0, 1'b0);
        run_frame(8'h14, 3, T + 1, 4'd5, 0, 1'b0, 1'b0);
        run_frame(8'h15, 20, 6, 4'd4, 0, 1'b0, 1'b1);
        run_frame(8'h16, 2, 1, 4'hC, 0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            d1 = int'($urandom_range(1, T + 3));
            d2 = int'($urandom_range(1, T + 3));
            run_frame(8'($urandom), d1, d2, 4'($urandom), int'($urandom_range(0, 4)),
                      1'($urandom), (d1 >= 5) ? 1'($urandom) : 1'b0);
        end
        reset_mid_frame();
        run_frame(8'hC3, 9, 11, 4'd8, 1, 1'b0, 1'b0);
        @(negedge clk);
        res_ready = 1'b0;
        check_counters();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
